uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter between N_REQ byte requesters.
- Sits between the requesters and the transmitter's data_tx / ready_tx / write_tx inputs.
- The transmitter provides no busy indication, so the block paces frames itself with a frame-time counter.
- It guarantees exactly one write strobe per accepted byte and never issues a write while a frame is still on the line.

Parameters:
- N_REQ, 4: number of requesters; legal range 2..8.
- FRAME_CYCLES, 10: clk_tx cycles one frame occupies the transmitter, start+8 data+stop, including any inter-frame gap; minimum 2.
- CNT_W, $clog2(FRAME_CYCLES): width of the frame counter (derived).
- ID_W, $clog2(N_REQ): width of grant_id (derived).

Ports:
- clk_tx  input  1  single clock for the whole block.
- rst_tx  input  1  synchronous, active-high reset.
- arb_en  input  1  1 = new grants allowed; a frame already in progress always completes.
- req_valid  input  N_REQ  per-requester byte-pending flag.
- req_data  input  8*N_REQ  byte for requester i on bits [8i+7:8i].
- req_ack  output  N_REQ  one-cycle pulse: byte accepted.
- data_tx  output  8  byte presented to the transmitter.
- ready_tx  output  1  high for the whole frame (SEND and BUSY).
- write_tx  output  1  one-cycle write strobe to the transmitter.
- busy  output  1  high in SEND and BUSY.
- grant_id  output  ID_W  index of the last granted requester.

Behaviour:
- States: IDLE, SEND, BUSY. All outputs and state are registered.
- Reset (rst_tx=1 at a clk_tx edge) forces:
  - state=IDLE, req_ack=0, write_tx=0, ready_tx=0, busy=0, data_tx=8'h00;
  - grant_id=N_REQ-1, so requester 0 has top priority after reset;
  - frame counter = 0.
  - Reset mid-frame aborts silently: no ack, no further write.
- IDLE: if arb_en=1 and any req_valid is set, pick the first set bit searching from grant_id+1 upward, wrapping modulo N_REQ. At that edge:
  - latch req_data of the winner into data_tx;
  - update grant_id;
  - go to SEND.
  - If arb_en=0 or no request is pending, remain in IDLE.
- SEND (exactly 1 cycle):
  - write_tx=1, ready_tx=1, busy=1;
  - req_ack[grant_id]=1, all other ack bits 0;
  - load counter with FRAME_CYCLES-2; go to BUSY.
- BUSY:
  - ready_tx=1, busy=1, write_tx=0, data_tx held stable;
  - counter decrements each cycle; when it is 0, go to IDLE on that edge.
  - SEND plus BUSY together last exactly FRAME_CYCLES cycles.
- Latency: a request sampled in IDLE at edge t produces write_tx and ack in cycle t+1.
- Throughput: under continuous requests, the minimum spacing between write_tx pulses is FRAME_CYCLES+1 cycles (one IDLE arbitration cycle).
- Requester contract:
  - hold req_valid and data stable until ack;
  - the byte is committed at the grant edge, so a valid dropped during SEND still gets its ack;
  - the requester may present its next byte the cycle after ack.
- Requests arriving during SEND/BUSY are ignored until IDLE; no request is lost while it is held.
- Fairness: a requester that holds valid is granted within N_REQ frames.
- Simultaneous requests: resolved purely by the round-robin pointer; there is no fixed priority except immediately after reset.
- arb_en falling during BUSY: the current frame finishes normally; the next grant waits for arb_en=1.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum type (IDLE/SEND/BUSY);
  - the default FRAME_CYCLES constant;
  - the byte width constant (8).
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, last grant index.
  - Outputs: winner index, any-valid flag.
  - It is reusable for a future RX fan-out arbiter.

Test Plan (N_REQ=4, FRAME_CYCLES=10):
1. Reset and enable: hold rst_tx for 2 cycles, then release with no requests -> all outputs 0, grant_id=3, state stays IDLE indefinitely.
2. Single request: req_valid=4'b0100, byte 0xA5, sampled in IDLE at edge t -> in cycle t+1: write_tx=1, data_tx=0xA5, req_ack=4'b0100. busy stays high for 10 cycles, then drops; no second write while valid is low.
3. Continuous contention: all four valid with bytes 0x10, 0x11, 0x12, 0x13 -> writes in order 0x10, 0x11, 0x12, 0x13, 0x10, with write_tx pulses exactly 11 cycles apart.
4. Pointer wrap: grant_id=1, and req 0 and req 3 are raised during BUSY -> next grant is 3, then 0.
5. Reset mid-frame: assert rst_tx in BUSY cycle 4 -> next cycle busy=0, ready_tx=0, write_tx=0. After release with req 0 and req 1 valid, req 0 is granted first.
6. Enable gating: arb_en=0 with req 2 valid -> no write for 50 cycles. Raise arb_en -> write_tx the cycle after the first IDLE edge with arb_en=1. Drop arb_en during BUSY -> that frame completes and no new grant follows.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: sequencer states and
// frame/byte sizing defaults.
package uart_pkg;

  localparam int BYTE_W             = 8;
  localparam int FRAME_CYCLES_DEF   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the shared UART TX arbiter.
// The arbiter uses the slave modport; the requesters/transmitter model use master.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);

  logic                      arb_en;
  logic [N_REQ-1:0]          req_valid;
  logic [BYTE_W*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]          req_ack;
  logic [BYTE_W-1:0]         data_tx;
  logic                      ready_tx;
  logic                      write_tx;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;

  modport master (
    output arb_en, req_valid, req_data,
    input  req_ack, data_tx, ready_tx, write_tx, busy, grant_id
  );

  modport slave (
    input  arb_en, req_valid, req_data,
    output req_ack, data_tx, ready_tx, write_tx, busy, grant_id
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request strictly after the
// last grant, wrapping modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    winner = last;
    any    = |req;
    // Walk from the farthest candidate back to the nearest so the nearest wins.
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        winner = IDX_W'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between N_REQ
// byte requesters; paces frames with its own counter since the TX has no busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int CNT_W        = $clog2(FRAME_CYCLES),
  parameter int ID_W         = $clog2(N_REQ)
) (
  input  logic             clk_tx,
  input  logic             rst_tx,
  uart_tx_arbiter_if.slave bus
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                write_q, busy_q;

  logic [ID_W-1:0]     winner;
  logic                any_req;

  rr_pick #(.N(N_REQ), .IDX_W(ID_W)) u_rr_pick (
    .req    (bus.req_valid),
    .last   (grant_q),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.arb_en && any_req) begin
          state_d = SEND;
          grant_d = winner;
          data_d  = bus.req_data[int'(winner)*BYTE_W +: BYTE_W];
        end
      end
      SEND: begin
        state_d = BUSY;
        cnt_d   = CNT_W'(FRAME_CYCLES - 2);
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    ack_d = (state_d == SEND) ? (N_REQ'(1) << grant_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_tx) begin
    if (rst_tx) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= ID_W'(N_REQ - 1);
      data_q  <= '0;
      ack_q   <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      write_q <= (state_d == SEND);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.req_ack  = ack_q;
  assign bus.data_tx  = data_q;
  assign bus.write_tx = write_q;
  assign bus.ready_tx = busy_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;

endmodule
